// File: rtl/nano_dmem_pkg.sv
// Shared definitions for the nano data-memory responder: funct3 codes,
// FSM state encodings and the captured request record.
package nano_dmem_pkg;

  localparam logic [2:0] INST_LB  = 3'd0;
  localparam logic [2:0] INST_LH  = 3'd1;
  localparam logic [2:0] INST_LW  = 3'd2;
  localparam logic [2:0] INST_LBU = 3'd4;
  localparam logic [2:0] INST_LHU = 3'd5;
  localparam logic [2:0] INST_SB  = 3'd0;
  localparam logic [2:0] INST_SH  = 3'd1;
  localparam logic [2:0] INST_SW  = 3'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } dmem_req_t;

  // Stores only know SB/SH/SW; loads additionally allow the unsigned forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 >= 3'd3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/nano_dmem_lane.sv
// Byte-lane steering for one access: load extraction/extension, store
// replication/strobes, and alignment/legality flags.
module nano_dmem_lane
  import nano_dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  strb_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    case (funct3_i)
      INST_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      INST_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      INST_LW:  rdata_o = rword_i;
      INST_LBU: rdata_o = {24'd0, byte_sel};
      INST_LHU: rdata_o = {16'd0, half_sel};
      default:  rdata_o = 32'd0;
    endcase

    // Replicate into every lane so the strobe alone selects what lands.
    case (funct3_i)
      INST_SB: begin
        wdata_o = {4{wdata_i[7:0]}};
        strb_o  = 4'b0001 << addr_lo_i;
      end
      INST_SH: begin
        wdata_o = {2{wdata_i[15:0]}};
        strb_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      INST_SW: begin
        wdata_o = wdata_i;
        strb_o  = 4'b1111;
      end
      default: begin
        wdata_o = 32'd0;
        strb_o  = 4'b0000;
      end
    endcase

    misalign_o = ((funct3_i[1:0] == 2'd1) && addr_lo_i[0]) ||
                 ((funct3_i[1:0] == 2'd2) && (addr_lo_i != 2'd0));
    illegal_o  = f3_illegal(we_i, funct3_i);
  end

endmodule

// File: rtl/nano_dmem.sv
// Data-memory responder: valid/ready request in, one response out per
// request after WAIT_CYCLES extra cycles, backed by a word-wide array.
module nano_dmem
  import nano_dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d, req_e;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        enter_resp, err_e;
  logic [AW-1:0] widx;
  logic [31:0] rword, lane_rdata, lane_wdata;
  logic [3:0]  lane_strb;
  logic        misalign, illegal;

  // With WAIT_CYCLES=0 the commit edge is the accept edge, so the live
  // request must be used before it has been captured.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_e.we     = i_req_we;
      req_e.addr   = i_req_addr;
      req_e.funct3 = i_req_funct3;
      req_e.wdata  = i_req_wdata;
    end else begin
      req_e = req_q;
    end
  end

  assign widx  = req_e.addr[AW+1:2];
  assign rword = mem[widx];

  nano_dmem_lane u_lane (
    .we_i       (req_e.we),
    .addr_lo_i  (req_e.addr[1:0]),
    .funct3_i   (req_e.funct3),
    .wdata_i    (req_e.wdata),
    .rword_i    (rword),
    .rdata_o    (lane_rdata),
    .wdata_o    (lane_wdata),
    .strb_o     (lane_strb),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  assign err_e = misalign || illegal || (req_e.addr[31:2] >= DEPTH_W);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        req_d = req_e;
        cnt_d = CNT_INIT;
        if (WAIT_CYCLES == 0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d    = S_RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: if (i_rsp_ready) begin
        state_d = S_IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = err_e;
      rdata_d = (err_e || req_e.we) ? 32'd0 : lane_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; reset only blocks a commit that would race it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && enter_resp && req_e.we && !err_e) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_strb[b]) mem[widx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_nano_dmem.sv
// Directed bench for nano_dmem: one instance with WAIT_CYCLES=1, one with 0.
module tb_nano_dmem;
  import nano_dmem_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, v0, v1, we, rsp_ready;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic        rdy0, rdy1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;
  logic        o_rdy, o_rv, o_er;
  logic [31:0] o_rd;
  int          sel;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          a0, a1;

  always @(posedge clk) cyc <= cyc + 1;

  nano_dmem #(.DEPTH(1024), .WAIT_CYCLES(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v0), .o_req_ready(rdy0),
    .i_req_we(we), .i_req_addr(addr), .i_req_funct3(f3), .i_req_wdata(wdata),
    .o_rsp_valid(rv0), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd0), .o_rsp_err(er0)
  );

  nano_dmem #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
    .i_req_we(we), .i_req_addr(addr), .i_req_funct3(f3), .i_req_wdata(wdata),
    .o_rsp_valid(rv1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd1), .o_rsp_err(er1)
  );

  always_comb begin
    o_rdy = (sel == 0) ? rdy0 : rdy1;
    o_rv  = (sel == 0) ? rv0  : rv1;
    o_rd  = (sel == 0) ? rd0  : rd1;
    o_er  = (sel == 0) ? er0  : er1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; hold>0 keeps i_rsp_ready low for that many cycles.
  task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                      input int hold, output int acc);
    int lat;
    sel = s; we = w; addr = a; f3 = f; wdata = d;
    rsp_ready = (hold == 0);
    if (s == 0) v0 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    acc = cyc;
    #1;
    v0 = 1'b0; v1 = 1'b0;
    addr = 32'hFFFF_FFFC; f3 = 3'd7; wdata = 32'h0BAD_0BAD;
    lat = 1;
    while (!o_rv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), (s == 0) ? 32'd2 : 32'd1);
    chk("rdata", o_rd, exp_rd);
    chk("err", {31'd0, o_er}, {31'd0, exp_err});
    chk("ready_busy", {31'd0, o_rdy}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, o_rv}, 32'd1);
      chk("hold_rdata", o_rd, exp_rd);
      chk("hold_err", {31'd0, o_er}, {31'd0, exp_err});
      chk("hold_ready", {31'd0, o_rdy}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after", {31'd0, o_rdy}, 32'd1);
    chk("valid_after", {31'd0, o_rv}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; we = 1'b0; addr = '0; wdata = '0; f3 = '0;
    rsp_ready = 1'b1; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, rdy0}, 32'd1);
    chk("rst_valid0", {31'd0, rv0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_err0", {31'd0, er0}, 32'd0);
    chk("rst_ready1", {31'd0, rdy1}, 32'd1);
    chk("rst_valid1", {31'd0, rv1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WAIT_CYCLES=1: store then reads of every width
    xact(0, 1, 32'h10, INST_SW, 32'hDEADBEEF, 32'h0, 0, 0, a0);
    xact(0, 0, 32'h10, INST_LW, 32'h0, 32'hDEADBEEF, 0, 0, a1);
    chk("period_w1", 32'(a1 - a0), 32'd3);
    xact(0, 0, 32'h13, INST_LB,  32'h0, 32'hFFFFFFDE, 0, 0, a0);
    xact(0, 0, 32'h13, INST_LBU, 32'h0, 32'h000000DE, 0, 0, a0);
    xact(0, 0, 32'h12, INST_LH,  32'h0, 32'hFFFFDEAD, 0, 0, a0);
    xact(0, 0, 32'h10, INST_LHU, 32'h0, 32'h0000BEEF, 0, 0, a0);
    xact(0, 1, 32'h11, INST_SB, 32'hFFFFFF55, 32'h0, 0, 0, a0);
    xact(0, 0, 32'h10, INST_LW, 32'h0, 32'hDEAD55EF, 0, 0, a0);
    xact(0, 1, 32'h12, INST_SH, 32'hAAAA1234, 32'h0, 0, 0, a0);
    xact(0, 0, 32'h10, INST_LW, 32'h0, 32'h123455EF, 0, 0, a0);

    // error cases must not write
    xact(0, 0, 32'h12,   INST_LW, 32'h0, 32'h0, 1, 0, a0);
    xact(0, 1, 32'h11,   INST_SH, 32'h0000FFFF, 32'h0, 1, 0, a0);
    xact(0, 0, 32'h1000, INST_LW, 32'h0, 32'h0, 1, 0, a0);
    xact(0, 0, 32'h10,   3'd3,    32'h0, 32'h0, 1, 0, a0);
    xact(0, 1, 32'h10,   3'd4,    32'h77777777, 32'h0, 1, 0, a0);
    xact(0, 1, 32'h1000, INST_SW, 32'h66666666, 32'h0, 1, 0, a0);
    xact(0, 0, 32'h10,   INST_LW, 32'h0, 32'h123455EF, 0, 0, a0);

    // backpressure
    xact(0, 0, 32'h10, INST_LH, 32'h0, 32'h000055EF, 0, 5, a0);

    // reset during WAIT of a store
    xact(0, 1, 32'h20, INST_SW, 32'h11111111, 32'h0, 0, 0, a0);
    sel = 0; we = 1'b1; addr = 32'h20; f3 = INST_SW; wdata = 32'hCAFEF00D; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk("abort_in_wait", {31'd0, rdy0}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, rdy0}, 32'd1);
    chk("abort_valid", {31'd0, rv0}, 32'd0);
    chk("abort_rdata", rd0, 32'd0);
    chk("abort_err", {31'd0, er0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 0, 32'h20, INST_LW, 32'h0, 32'h11111111, 0, 0, a0);

    // WAIT_CYCLES=0: back-to-back
    xact(1, 1, 32'h40, INST_SW, 32'hA5A51234, 32'h0, 0, 0, a0);
    xact(1, 0, 32'h40, INST_LW, 32'h0, 32'hA5A51234, 0, 0, a1);
    chk("period_w0_a", 32'(a1 - a0), 32'd2);
    xact(1, 0, 32'h41, INST_LBU, 32'h0, 32'h00000012, 0, 0, a0);
    chk("period_w0_b", 32'(a0 - a1), 32'd2);
    xact(1, 0, 32'h42, INST_LH, 32'h0, 32'hFFFFA5A5, 0, 0, a1);
    chk("period_w0_c", 32'(a1 - a0), 32'd2);
    xact(1, 0, 32'h43, INST_LW, 32'h0, 32'h0, 1, 0, a0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
